tile_render_sequencer: RTL
==========================

Name: tile_render_sequencer

Overview:
- Frame-fill controller that sequences the per-tile graphic lookup blocks (wall, pellet, empty, ...) to paint the maze into the frame buffer.
- On a start pulse it walks the tile map row-major and reads each tile's type from map memory.
- For each tile it steps the relative x/y through all PIXELS_WIDTH x PIXELS_WIDTH pixels and streams the returned colour to the frame buffer over a valid/ready write port.
- It sits between the maze map RAM, the graphic blocks (muxed externally by tile_type) and the frame-buffer writer.

Parameters:
- PIXELS_WIDTH, 16, tile edge in pixels (power of two).
- REL_BITS, 4, log2(PIXELS_WIDTH); width of gfx_x/gfx_y.
- PIXEL_COLOR_BITS, 8, colour width (RRRGGGBB).
- MAP_COLS, 28, tiles per row.
- MAP_ROWS, 31, tile rows.
- MAP_ADDR_BITS, 10, map address width; must satisfy MAP_COLS*MAP_ROWS <= 2^MAP_ADDR_BITS.
- TILE_TYPE_BITS, 2, tile type width; type 0 means empty.
- FB_ADDR_BITS, 18, frame-buffer address width.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to render one frame.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse when the frame is complete.
- map_rd_en, output, 1, map read strobe.
- map_addr, output, MAP_ADDR_BITS, tile index, equal to row*MAP_COLS+col.
- map_tile, input, TILE_TYPE_BITS, map read data, valid the cycle after map_rd_en.
- tile_type, output, TILE_TYPE_BITS, registered type of the current tile; drives the external graphic mux.
- gfx_x, output, REL_BITS, registered relative x to the graphic blocks.
- gfx_y, output, REL_BITS, registered relative y to the graphic blocks.
- gfx_pixel, input, PIXEL_COLOR_BITS, combinational colour returned for (gfx_x, gfx_y).
- wr_valid, output, 1, frame-buffer write request.
- wr_ready, input, 1, frame-buffer accepts the write.
- wr_addr, output, FB_ADDR_BITS, linear pixel address.
- wr_data, output, PIXEL_COLOR_BITS, pixel colour.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, map_rd_en and wr_valid = 0. map_addr, tile_type, gfx_x, gfx_y, wr_addr = 0. Internal col and row = 0.
- IDLE:
  - start=1 -> MAP_RD; col and row are cleared.
  - start is ignored in every other state; no queuing.
- MAP_RD (1 cycle): map_rd_en=1, map_addr=row*MAP_COLS+col, busy=1 -> MAP_WAIT.
- MAP_WAIT (1 cycle): map_rd_en=0; tile_type<=map_tile; gfx_x and gfx_y <= 0 -> PIX.
- PIX:
  - wr_valid=1.
  - wr_addr = (row*PIXELS_WIDTH+gfx_y)*(MAP_COLS*PIXELS_WIDTH) + col*PIXELS_WIDTH + gfx_x, truncated to FB_ADDR_BITS.
  - wr_data = gfx_pixel if tile_type != 0, else 0.
  - wr_valid && !wr_ready: gfx_x, gfx_y, wr_addr and wr_data hold stable. wr_valid is never dropped mid-pixel.
  - Accept (wr_valid && wr_ready):
    - gfx_x increments.
    - At gfx_x=PIXELS_WIDTH-1, gfx_x wraps to 0 and gfx_y increments.
    - At the last pixel of the tile (both fields at PIXELS_WIDTH-1), col increments and state -> MAP_RD.
    - If col=MAP_COLS-1, col wraps to 0 and row increments.
    - If additionally row=MAP_ROWS-1, state -> DONE instead.
- DONE (1 cycle): done=1, busy=0, wr_valid=0 -> IDLE. done and start may coincide; that start is ignored.
- Latency:
  - First wr_valid appears 3 cycles after the clock edge that samples start.
  - With wr_ready held at 1, each tile costs 2+PIXELS_WIDTH^2 cycles.
  - The frame costs MAP_COLS*MAP_ROWS*(2+PIXELS_WIDTH^2) cycles, then 1 DONE cycle.
  - Defaults: 868*258 = 223944 cycles.
- Address arithmetic: use widths sufficient for the full product before truncation. No overflow is permitted at default parameters (max address 222207 < 2^18).
- Reset mid-frame: all outputs are forced to reset values immediately. No done pulse. A new start is required.

Test Plan:
Bench parameters unless stated: PIXELS_WIDTH=4, MAP_COLS=2, MAP_ROWS=2; map types {1,2,0,1}; gfx model returns {y,x} packed into the colour byte.
- Full frame, wr_ready=1, single start pulse:
  - Exactly 64 writes; done 73 cycles after the start sample.
  - Addresses 0..63 each written exactly once.
  - Tile (col 1, row 1) pixel x=3, y=2 writes addr 55.
- Empty tile (map index 2, type 0): all 16 writes for that tile carry wr_data=0, addresses 32..35, 40..43, 48..51, 56..59.
- Backpressure: wr_ready toggles 1,0,0,1 repeating:
  - wr_addr and wr_data are stable while stalled.
  - Still 64 writes with no duplicates or skips.
  - done asserts only after the 64th accept.
- Start while busy (pulse start at cycle 20): ignored; a single done pulse and write count 64.
- Reset mid-operation (rst_n low for 1 cycle at write 30, asynchronous, mid-clock):
  - busy, wr_valid and map_rd_en drop before the next edge.
  - No done pulse.
  - A following start re-renders from addr 0.
- Default parameters, wr_ready=1: done at cycle 223945 after the start sample; last write addr 222207.

Source files
------------

// File: rtl/tile_render_sequencer.sv
// Frame-fill sequencer: walks the tile map row-major, fetches each tile type and
// streams every pixel of every tile to the frame buffer over a valid/ready port.
module tile_render_sequencer #(
  parameter int PIXELS_WIDTH     = 16,
  parameter int REL_BITS         = 4,
  parameter int PIXEL_COLOR_BITS = 8,
  parameter int MAP_COLS         = 28,
  parameter int MAP_ROWS         = 31,
  parameter int MAP_ADDR_BITS    = 10,
  parameter int TILE_TYPE_BITS   = 2,
  parameter int FB_ADDR_BITS     = 18
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        map_rd_en,
  output logic [MAP_ADDR_BITS-1:0]    map_addr,
  input  logic [TILE_TYPE_BITS-1:0]   map_tile,
  output logic [TILE_TYPE_BITS-1:0]   tile_type,
  output logic [REL_BITS-1:0]         gfx_x,
  output logic [REL_BITS-1:0]         gfx_y,
  input  logic [PIXEL_COLOR_BITS-1:0] gfx_pixel,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [FB_ADDR_BITS-1:0]     wr_addr,
  output logic [PIXEL_COLOR_BITS-1:0] wr_data
);

  localparam int COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam int ROW_W = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;
  localparam int LINE_PIXELS = MAP_COLS * PIXELS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAP_RD,
    S_MAP_WAIT,
    S_PIX,
    S_DONE
  } state_t;

  state_t                      state_reg, state_next;
  logic                        start_reg;
  logic [COL_W-1:0]            col_reg, col_next;
  logic [ROW_W-1:0]            row_reg, row_next;
  logic [TILE_TYPE_BITS-1:0]   tile_type_next;
  logic [REL_BITS-1:0]         gfx_x_next, gfx_y_next;
  logic                        last_x, last_y, last_col, last_row;

  assign last_x   = (gfx_x == REL_BITS'(PIXELS_WIDTH - 1));
  assign last_y   = (gfx_y == REL_BITS'(PIXELS_WIDTH - 1));
  assign last_col = (col_reg == COL_W'(MAP_COLS - 1));
  assign last_row = (row_reg == ROW_W'(MAP_ROWS - 1));

  // start is sampled into a register and only honoured while idle, so a start
  // arriving during DONE (or mid-frame) is dropped rather than queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      start_reg <= 1'b0;
      col_reg   <= '0;
      row_reg   <= '0;
      tile_type <= '0;
      gfx_x     <= '0;
      gfx_y     <= '0;
    end else begin
      state_reg <= state_next;
      start_reg <= start && (state_reg == S_IDLE);
      col_reg   <= col_next;
      row_reg   <= row_next;
      tile_type <= tile_type_next;
      gfx_x     <= gfx_x_next;
      gfx_y     <= gfx_y_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    tile_type_next = tile_type;
    gfx_x_next     = gfx_x;
    gfx_y_next     = gfx_y;
    case (state_reg)
      S_IDLE: begin
        if (start_reg) begin
          col_next   = '0;
          row_next   = '0;
          state_next = S_MAP_RD;
        end
      end
      S_MAP_RD: state_next = S_MAP_WAIT;
      S_MAP_WAIT: begin
        tile_type_next = map_tile;
        gfx_x_next     = '0;
        gfx_y_next     = '0;
        state_next     = S_PIX;
      end
      S_PIX: begin
        if (wr_ready) begin
          gfx_x_next = last_x ? '0 : gfx_x + REL_BITS'(1);
          if (last_x) begin
            gfx_y_next = last_y ? '0 : gfx_y + REL_BITS'(1);
          end
          if (last_x && last_y) begin
            if (last_col) begin
              col_next = '0;
              if (last_row) begin
                row_next   = '0;
                state_next = S_DONE;
              end else begin
                row_next   = row_reg + ROW_W'(1);
                state_next = S_MAP_RD;
              end
            end else begin
              col_next   = col_reg + COL_W'(1);
              state_next = S_MAP_RD;
            end
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy      = (state_reg == S_MAP_RD) || (state_reg == S_MAP_WAIT) || (state_reg == S_PIX);
  assign done      = (state_reg == S_DONE);
  assign map_rd_en = (state_reg == S_MAP_RD);
  assign wr_valid  = (state_reg == S_PIX);

  // Address products are formed at 64 bits and truncated only at the port.
  assign map_addr = MAP_ADDR_BITS'(64'(row_reg) * 64'(MAP_COLS) + 64'(col_reg));
  assign wr_addr  = FB_ADDR_BITS'((64'(row_reg) * 64'(PIXELS_WIDTH) + 64'(gfx_y)) * 64'(LINE_PIXELS)
                                  + 64'(col_reg) * 64'(PIXELS_WIDTH) + 64'(gfx_x));
  assign wr_data  = (tile_type != '0) ? gfx_pixel : '0;

endmodule
